net_vector_sequencer: RTL and testbench

//  Clocked stimulus/check stage wrapped around the fun1 net-variable block.

---
 rtl/net_vector_sequencer_pkg.sv | 18 +
 rtl/net_vector_sequencer_if.sv | 42 ++++
 rtl/net_vector_sequencer_timer.sv | 36 +++
 rtl/net_vector_sequencer.sv | 150 +++++++++++++++
 tb/tb_net_vector_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/net_vector_sequencer_pkg.sv
// net_seq_pkg
//   Shared definitions for the net-variable vector sequencer: the sweep
//   size, the index and error-counter widths, and the FSM state encoding.
//   There are no ports; the interface, the hold timer and the top import it.
package net_seq_pkg;

  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = 4;
  localparam int ERR_W       = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/net_vector_sequencer_if.sv
// net_vector_sequencer_if
//   Bundles the sequencer's control, stimulus and result signals.
//   slave  : the sequencer side. It receives start/abort, f_in and exp_vec.
//            It drives a..d, vec_idx, busy, sample_valid, sample_data,
//            mismatch, err_count, first_err_idx and done.
//   master : the controller side, with the directions reversed.
interface net_vector_sequencer_if
  import net_seq_pkg::*;
#(
  parameter int NUM_OUT = 6
);

  logic               start;
  logic               abort;
  logic [NUM_OUT-1:0] f_in;
  logic [NUM_OUT-1:0] exp_vec;
  logic               a;
  logic               b;
  logic               c;
  logic               d;
  logic [IDX_W-1:0]   vec_idx;
  logic               busy;
  logic               sample_valid;
  logic [NUM_OUT-1:0] sample_data;
  logic               mismatch;
  logic [ERR_W-1:0]   err_count;
  logic [IDX_W-1:0]   first_err_idx;
  logic               done;

  modport slave (
    input  start, abort, f_in, exp_vec,
    output a, b, c, d, vec_idx, busy, sample_valid, sample_data,
           mismatch, err_count, first_err_idx, done
  );

  modport master (
    output start, abort, f_in, exp_vec,
    input  a, b, c, d, vec_idx, busy, sample_valid, sample_data,
           mismatch, err_count, first_err_idx, done
  );

endinterface

// File: rtl/net_vector_sequencer_timer.sv
// net_seq_hold_timer
//   A down-counter that sets how long each vector is held.
//   - clear   : reloads the count to HOLD_CYCLES-1.
//   - enable  : decrements the count until it reaches zero.
//   - tc      : terminal-count flag, high while the count is zero.
//   After a clear, tc first goes high HOLD_CYCLES-1 enabled clocks later.
//   Ports: clk, rst_n (async, active low), clear, enable, tc.
module net_seq_hold_timer #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] count;

  // A clear has priority over an enable. The counter saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/net_vector_sequencer.sv
// net_vector_sequencer
//   Sweeps the 16 {d,c,b,a} combinations into the fun1 block.
//   Each combination is held for HOLD_CYCLES clocks and then sampled for one clock.
//   Each sampled result is compared with the golden exp_vec, and mismatches are counted.
//   Ports: clk, rst_n (async, active low), bus (net_vector_sequencer_if.slave):
//     start/abort     sweep control (abort has priority)
//     f_in/exp_vec    fun1 result and golden value for the applied vector
//     a..d, vec_idx   applied vector
//     busy, done      sweep status
//     sample_valid, sample_data, mismatch   per-vector result
//     err_count, first_err_idx              sweep error summary
//   Every output comes from a flop.
module net_vector_sequencer
  import net_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int NUM_OUT     = 6
) (
  input logic                   clk,
  input logic                   rst_n,
  net_vector_sequencer_if.slave bus
);

  seq_state_t         state;
  seq_state_t         state_next;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   idx_next;
  logic [IDX_W-1:0]   drive_vec;
  logic [NUM_OUT-1:0] sample_reg;
  logic [ERR_W-1:0]   err_reg;
  logic [IDX_W-1:0]   first_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               valid_reg;
  logic               miss_reg;
  logic               timer_clear;
  logic               timer_enable;
  logic               timer_tc;
  logic               do_sample;
  logic               start_sweep;
  logic               differs;

  net_seq_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .tc     (timer_tc)
  );

  // Case inequality is used so that an X or Z on any f_in bit counts as a mismatch.
  assign differs = (bus.f_in !== bus.exp_vec);

  // Next-state logic. Abort overrides everything. A start pulse only matters
  // from IDLE or DONE, so a start during a sweep cannot disturb the timer or
  // the index. The last vector leaves the index at 15 rather than wrapping it.
  always_comb begin
    state_next   = state;
    idx_next     = cur_idx;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    do_sample    = 1'b0;
    start_sweep  = 1'b0;
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state_next  = APPLY;
            idx_next    = '0;
            timer_clear = 1'b1;
            start_sweep = 1'b1;
          end
        end
        APPLY: begin
          if (timer_tc) begin
            state_next = SAMPLE;
          end else begin
            timer_enable = 1'b1;
          end
        end
        SAMPLE: begin
          do_sample = 1'b1;
          if (cur_idx == IDX_W'(NUM_VECTORS - 1)) begin
            state_next = DONE;
          end else begin
            idx_next    = cur_idx + IDX_W'(1);
            state_next  = APPLY;
            timer_clear = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register and output flops. The status and drive outputs are
  // computed from the next state, so they change on the same edge as the FSM.
  // The error bookkeeping is cleared only when a new sweep starts, so the
  // error summary is still readable after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_idx    <= '0;
      drive_vec  <= '0;
      sample_reg <= '0;
      err_reg    <= '0;
      first_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      miss_reg   <= 1'b0;
    end else begin
      state     <= state_next;
      cur_idx   <= idx_next;
      drive_vec <= (state_next == IDLE) ? '0 : idx_next;
      busy_reg  <= (state_next == APPLY) || (state_next == SAMPLE);
      done_reg  <= (state_next == DONE);
      valid_reg <= do_sample;
      miss_reg  <= do_sample && differs;
      if (start_sweep) begin
        err_reg   <= '0;
        first_reg <= '0;
      end else if (do_sample) begin
        sample_reg <= bus.f_in;
        if (differs) begin
          if (err_reg == '0) begin
            first_reg <= cur_idx;
          end
          err_reg <= err_reg + ERR_W'(1);
        end
      end
    end
  end

  assign bus.a             = drive_vec[0];
  assign bus.b             = drive_vec[1];
  assign bus.c             = drive_vec[2];
  assign bus.d             = drive_vec[3];
  assign bus.vec_idx       = cur_idx;
  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;
  assign bus.sample_valid  = valid_reg;
  assign bus.sample_data   = sample_reg;
  assign bus.mismatch      = miss_reg;
  assign bus.err_count     = err_reg;
  assign bus.first_err_idx = first_reg;

endmodule

// File: tb/tb_net_vector_sequencer.sv
// tb_net_vector_sequencer
//   Self-checking bench for net_vector_sequencer.
//   The bench contains a behavioural fun1 model that answers the sequencer's a..d outputs.
//   Per-vector flip masks corrupt either f_in or the golden value.
//   The expected sample data, mismatch pulses, pulse timing and error summary
//   are worked out directly from those masks.
module tb_net_vector_sequencer;
  import net_seq_pkg::*;

  localparam int HOLD = 2;
  localparam int NOUT = 6;
  localparam int PER  = HOLD + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [NOUT-1:0] f_flip   [16];
  logic [NOUT-1:0] exp_flip [16];
  logic [3:0]      drv_idx;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  net_vector_sequencer_if #(.NUM_OUT(NOUT)) bus ();

  net_vector_sequencer #(.HOLD_CYCLES(HOLD), .NUM_OUT(NOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural fun1 outputs. The bit order is
  // {f_supply1, f_supply0, f_wand, f_wor, f_tri, f_wire}.
  function automatic logic [NOUT-1:0] fun1_model(input logic [3:0] v);
    logic a, b, c, d;
    {d, c, b, a} = v;
    return {1'b1, 1'b0, (a | b) & (c | d), (a & b) | (c & d), c | d, a & b};
  endfunction

  // The fun1 block and the golden model both respond combinationally to the applied vector.
  always_comb begin
    drv_idx     = {bus.d, bus.c, bus.b, bus.a};
    bus.f_in    = fun1_model(drv_idx) ^ f_flip[drv_idx];
    bus.exp_vec = fun1_model(drv_idx) ^ exp_flip[drv_idx];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic ab);
    @(negedge clk);
    bus.start = s;
    bus.abort = ab;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic clearFlips();
    for (int k = 0; k < 16; k++) begin
      f_flip[k]   = '0;
      exp_flip[k] = '0;
    end
  endtask

  task automatic waitIdx(input int target);
    int n = 0;
    while (bus.vec_idx != 4'(target) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_idx", 32'(bus.vec_idx), 32'(target));
  endtask

  // Runs one full sweep and checks it against the flip masks.
  // When extra_starts is set, start is pulsed during vectors 3 and 10.
  // Those pulses must leave the sweep unchanged.
  task automatic runSweep(input bit extra_starts);
    int  t0;
    int  n;
    int  exp_err = 0;
    int  exp_first = 0;
    logic [NOUT-1:0] diff;
    applyStimulus(1'b1, 1'b0);
    t0 = cyc;
    checkOutput("busy_after_start", 32'(bus.busy), 1);
    checkOutput("idx_after_start", 32'(bus.vec_idx), 0);
    checkOutput("err_cleared", 32'(bus.err_count), 0);
    for (int k = 0; k < 16; k++) begin
      diff = f_flip[k] ^ exp_flip[k];
      if (diff != '0) begin
        if (exp_err == 0) exp_first = k;
        exp_err++;
      end
    end
    for (int k = 0; k < 16; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        bus.start = (extra_starts && (k == 3 || k == 10) && n == 1) ? 1'b1 : 1'b0;
      end while (!bus.sample_valid && n < 20);
      bus.start = 1'b0;
      if (!bus.sample_valid) begin
        checkOutput("sample_timeout", 0, 1);
        break;
      end
      diff = f_flip[k] ^ exp_flip[k];
      checkOutput($sformatf("sample_time_%0d", k), 32'(cyc - t0), 32'(PER * (k + 1)));
      checkOutput($sformatf("sample_data_%0d", k), 32'(bus.sample_data),
                  32'(fun1_model(4'(k)) ^ f_flip[k]));
      checkOutput($sformatf("mismatch_%0d", k), 32'(bus.mismatch), 32'(diff != '0));
    end
    checkOutput("done_rise", 32'(bus.done), 1);
    checkOutput("busy_at_end", 32'(bus.busy), 0);
    checkOutput("err_count", 32'(bus.err_count), 32'(exp_err));
    checkOutput("first_err_idx", 32'(bus.first_err_idx), 32'(exp_first));
    checkOutput("abcd_hold", 32'({bus.d, bus.c, bus.b, bus.a}), 15);
    repeat (3) @(negedge clk);
    checkOutput("done_level", 32'(bus.done), 1);
    checkOutput("valid_quiet", 32'(bus.sample_valid), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    clearFlips();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_status", 32'({bus.busy, bus.done, bus.sample_valid, bus.mismatch}), 0);
    checkOutput("reset_abcd", 32'({bus.d, bus.c, bus.b, bus.a}), 0);
    checkOutput("reset_summary", 32'({bus.err_count, bus.first_err_idx, bus.vec_idx}), 0);
    checkOutput("reset_data", 32'(bus.sample_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] clean sweep");
    runSweep(1'b0);

    $display("[TB] start pulses while busy");
    runSweep(1'b1);

    $display("[TB] golden bit 2 wrong at 5 and 12");
    exp_flip[5]  = 6'h04;
    exp_flip[12] = 6'h04;
    runSweep(1'b0);

    $display("[TB] f_in bit 1 wrong at 9");
    clearFlips();
    f_flip[9] = 6'h02;
    runSweep(1'b0);

    for (int r = 0; r < 3; r++) begin
      $display("[TB] random flip sweep %0d", r);
      clearFlips();
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 0) f_flip[k] = 6'($urandom_range(1, 63));
          else exp_flip[k] = 6'($urandom_range(1, 63));
        end
      end
      runSweep(1'b0);
    end

    $display("[TB] abort from done");
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_done_level", 32'(bus.done), 0);

    $display("[TB] abort during vector 4");
    clearFlips();
    exp_flip[1] = 6'h01;
    applyStimulus(1'b1, 1'b0);
    waitIdx(4);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abort_busy", 32'(bus.busy), 0);
    checkOutput("abort_done", 32'(bus.done), 0);
    checkOutput("abort_abcd", 32'({bus.d, bus.c, bus.b, bus.a}), 0);
    checkOutput("abort_err_kept", 32'(bus.err_count), 1);
    checkOutput("abort_first_kept", 32'(bus.first_err_idx), 1);

    $display("[TB] start and abort together from idle");
    applyStimulus(1'b1, 1'b1);
    checkOutput("both_busy", 32'(bus.busy), 0);
    checkOutput("both_done", 32'(bus.done), 0);
    repeat (4) @(negedge clk);
    checkOutput("both_still_idle", 32'(bus.busy), 0);

    clearFlips();
    runSweep(1'b0);

    $display("[TB] reset at vector 7");
    applyStimulus(1'b1, 1'b0);
    waitIdx(7);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_status", 32'({bus.busy, bus.done, bus.sample_valid, bus.mismatch}), 0);
    checkOutput("midrst_abcd", 32'({bus.d, bus.c, bus.b, bus.a}), 0);
    checkOutput("midrst_idx", 32'(bus.vec_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    f_flip[0] = 6'h20;
    runSweep(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
